// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and key tracker.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  localparam int KEY_W = 9;
  localparam logic [KEY_W-1:0] KEY_NONE = 9'h0F0;

  // Keyboard status/handshake bytes that never describe a key.
  localparam int N_IGNORED = 6;
  localparam logic [7:0] PS2_IGNORED [N_IGNORED] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  function automatic logic is_ignored(input logic [7:0] b);
    is_ignored = 1'b0;
    for (int i = 0; i < N_IGNORED; i++) begin
      if (b == PS2_IGNORED[i]) is_ignored = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronises and filters the pad lines, deframes 11-bit
// frames, and emits single-cycle byte/error strobes in the cycle of the stop edge.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int CLK_FILT    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FILT_W = $clog2(CLK_FILT + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        clk_sync;
  logic [1:0]        dat_sync;
  logic              filt_clk;
  logic [FILT_W-1:0] filt_cnt;
  logic              filt_flip;
  logic              fall;
  logic              dat;

  rx_state_e         state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              par_ok;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;

  // Idle PS/2 lines are high, so the synchronisers reset to 1.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  assign dat       = dat_sync[1];
  assign filt_flip = (clk_sync[1] != filt_clk) && (filt_cnt == FILT_W'(CLK_FILT - 1));
  assign fall      = filt_flip && filt_clk;

  // The filtered clock only follows after CLK_FILT consecutive differing samples.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign to_hit   = (state != ST_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign rx_byte  = shift;
  assign rx_valid = (state == ST_STOP) && fall && dat && par_ok;
  assign rx_err   = ((state == ST_STOP) && fall && !(dat && par_ok)) || to_hit;

  // Frame FSM advances only on filtered falling edges; timeout aborts a stalled frame.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else if (to_hit) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else if (fall) begin
      to_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (!dat) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shift   <= {dat, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: begin
          par_ok <= ^{shift, dat};
          state  <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end with E0/F0 prefix decoding and a table of held keys.
// Define PS2_EXT_KEY_EN to decode the E0 prefix into the ext bit of key_code.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int KEY_SLOTS   = 2,
  parameter int CLK_FILT    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       ps2_clk,
  input  logic                       ps2_dat,
  input  logic                       clear,
  output logic [7:0]                 scandata,
  output logic                       scan_valid,
  output logic                       frame_err,
  output logic                       key_ovf,
  output logic [KEY_SLOTS-1:0]       key_on,
  output logic [KEY_SLOTS*KEY_W-1:0] key_code,
  output logic [3:0]                 key_count
);

`ifdef PS2_EXT_KEY_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic [7:0]                 rx_byte;
  logic                       rx_valid;
  logic                       rx_err;

  logic                       ext_flag;
  logic                       brk_flag;
  logic                       is_e0;
  logic                       is_f0;
  logic                       is_skip;
  logic                       key_byte;
  logic [KEY_W-1:0]           cur_code;

  logic [KEY_SLOTS-1:0]       hit_mask;
  logic [KEY_SLOTS-1:0]       free_sel;
  logic [KEY_SLOTS-1:0]       next_on;
  logic [KEY_SLOTS*KEY_W-1:0] next_code;
  logic [3:0]                 next_count;
  logic                       ovf_next;

  ps2_rx_frame #(
    .CLK_FILT    (CLK_FILT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  // Without extended-key support E0 falls into the ignored class.
  assign is_e0    = EXT_EN && (rx_byte == PS2_E0);
  assign is_f0    = (rx_byte == PS2_F0);
  assign is_skip  = is_ignored(rx_byte) || (!EXT_EN && (rx_byte == PS2_E0));
  assign key_byte = rx_valid && !is_e0 && !is_f0 && !is_skip;
  assign cur_code = {ext_flag, rx_byte};

  // Next table state: break clears the matching slot, make fills the lowest free slot.
  always_comb begin
    hit_mask   = '0;
    free_sel   = '0;
    next_on    = key_on;
    next_code  = key_code;
    next_count = '0;
    ovf_next   = 1'b0;

    for (int i = KEY_SLOTS - 1; i >= 0; i--) begin
      hit_mask[i] = key_on[i] && (key_code[i*KEY_W +: KEY_W] == cur_code);
      if (!key_on[i]) free_sel = KEY_SLOTS'(1) << i;
    end

    if (key_byte) begin
      if (brk_flag) begin
        for (int i = 0; i < KEY_SLOTS; i++) begin
          if (hit_mask[i]) begin
            next_on[i]                  = 1'b0;
            next_code[i*KEY_W +: KEY_W] = KEY_NONE;
          end
        end
      end else if (hit_mask == '0) begin
        if (free_sel == '0) begin
          ovf_next = 1'b1;
        end else begin
          for (int i = 0; i < KEY_SLOTS; i++) begin
            if (free_sel[i]) begin
              next_on[i]                  = 1'b1;
              next_code[i*KEY_W +: KEY_W] = cur_code;
            end
          end
        end
      end
    end

    for (int i = 0; i < KEY_SLOTS; i++) begin
      next_count = next_count + 4'(next_on[i]);
    end
  end

  // Prefix flags persist across prefix bytes and drop after any other byte.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (rx_valid) begin
      if (is_e0) begin
        ext_flag <= 1'b1;
      end else if (is_f0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // clear overrides a same-cycle table update but leaves the byte strobes alone.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      scandata   <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      key_ovf    <= 1'b0;
      key_on     <= '0;
      key_code   <= {KEY_SLOTS{KEY_NONE}};
      key_count  <= '0;
    end else begin
      scan_valid <= rx_valid;
      frame_err  <= rx_err;
      key_ovf    <= ovf_next;
      if (rx_valid) scandata <= rx_byte;
      if (clear) begin
        key_on    <= '0;
        key_code  <= {KEY_SLOTS{KEY_NONE}};
        key_count <= '0;
      end else begin
        key_on    <= next_on;
        key_code  <= next_code;
        key_count <= next_count;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: table-driven frames plus corner sequences.
module tb_ps2_key_tracker;

  localparam int KEY_SLOTS   = 2;
  localparam int CLK_FILT    = 4;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 20;

`ifdef PS2_EXT_KEY_EN
  localparam logic [8:0] CODE_75 = 9'h175;
`else
  localparam logic [8:0] CODE_75 = 9'h075;
`endif

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        clear   = 1'b0;
  logic [7:0]  scandata;
  logic        scan_valid;
  logic        frame_err;
  logic        key_ovf;
  logic [1:0]  key_on;
  logic [17:0] key_code;
  logic [3:0]  key_count;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_ovf   = 0;

  typedef struct {
    logic [7:0]  data;
    bit          bad_par;
    int          exp_valid;
    int          exp_err;
    int          exp_ovf;
    logic [1:0]  exp_on;
    logic [17:0] exp_code;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  ps2_key_tracker #(
    .KEY_SLOTS   (KEY_SLOTS),
    .CLK_FILT    (CLK_FILT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .clear      (clear),
    .scandata   (scandata),
    .scan_valid (scan_valid),
    .frame_err  (frame_err),
    .key_ovf    (key_ovf),
    .key_on     (key_on),
    .key_code   (key_code),
    .key_count  (key_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse counters sampled away from the active edge; each high cycle counts once.
  always @(negedge sys_clk) begin
    if (scan_valid) n_valid++;
    if (frame_err)  n_err++;
    if (key_ovf)    n_ovf++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2 - 2);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] data, input bit bad_par);
    logic par;
    par = ~(^data) ^ bad_par;
    return {1'b1, par, data, 1'b0};
  endfunction

  task automatic applyStimulus(input logic [7:0] data, input bit bad_par, input int glitch_bit);
    send_bits(make_frame(data, bad_par), 11, glitch_bit);
    wait_cyc(4);
  endtask

  function automatic void add_vec(input logic [7:0] d, input bit bp, input int v, input int e,
                                  input int o, input logic [1:0] on, input logic [17:0] code,
                                  input int cnt);
    vec_t t;
    t.data = d; t.bad_par = bp; t.exp_valid = v; t.exp_err = e; t.exp_ovf = o;
    t.exp_on = on; t.exp_code = code; t.exp_cnt = cnt;
    vecs.push_back(t);
  endfunction

  initial begin
    int v0, e0, o0;
    logic [7:0] exp_scan;

    //        data   bp v e o  on     code {slot1,slot0}    cnt
    add_vec(8'h1C, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h01C}, 1);
    add_vec(8'h1C, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h01C}, 1);
    add_vec(8'h1C, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h01C}, 1);
    add_vec(8'hF0, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h01C}, 1);
    add_vec(8'h1C, 0, 1, 0, 0, 2'b00, {9'h0F0, 9'h0F0}, 0);
    add_vec(8'h1C, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h01C}, 1);
    add_vec(8'h1B, 0, 1, 0, 0, 2'b11, {9'h01B, 9'h01C}, 2);
    add_vec(8'h23, 0, 1, 0, 1, 2'b11, {9'h01B, 9'h01C}, 2);
    add_vec(8'hF0, 0, 1, 0, 0, 2'b11, {9'h01B, 9'h01C}, 2);
    add_vec(8'h1C, 0, 1, 0, 0, 2'b10, {9'h01B, 9'h0F0}, 1);
    add_vec(8'h23, 0, 1, 0, 0, 2'b11, {9'h01B, 9'h023}, 2);
    add_vec(8'h1C, 1, 0, 1, 0, 2'b11, {9'h01B, 9'h023}, 2);
    add_vec(8'hFA, 0, 1, 0, 0, 2'b11, {9'h01B, 9'h023}, 2);
    add_vec(8'hF0, 0, 1, 0, 0, 2'b11, {9'h01B, 9'h023}, 2);
    add_vec(8'h1B, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h023}, 1);
    add_vec(8'hF0, 0, 1, 0, 0, 2'b01, {9'h0F0, 9'h023}, 1);
    add_vec(8'h23, 0, 1, 0, 0, 2'b00, {9'h0F0, 9'h0F0}, 0);
    add_vec(8'hE0, 0, 1, 0, 0, 2'b00, {9'h0F0, 9'h0F0}, 0);
    add_vec(8'h75, 0, 1, 0, 0, 2'b01, {9'h0F0, CODE_75}, 1);
    add_vec(8'hE0, 0, 1, 0, 0, 2'b01, {9'h0F0, CODE_75}, 1);
    add_vec(8'hF0, 0, 1, 0, 0, 2'b01, {9'h0F0, CODE_75}, 1);
    add_vec(8'h75, 0, 1, 0, 0, 2'b00, {9'h0F0, 9'h0F0}, 0);

    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    checkOutput("reset scan_valid", 32'(scan_valid), 0);
    checkOutput("reset frame_err", 32'(frame_err), 0);
    checkOutput("reset key_ovf", 32'(key_ovf), 0);
    checkOutput("reset scandata", 32'(scandata), 0);
    checkOutput("reset key_on", 32'(key_on), 0);
    checkOutput("reset key_code", 32'(key_code), 32'({9'h0F0, 9'h0F0}));
    checkOutput("reset key_count", 32'(key_count), 0);

    exp_scan = 8'h00;
    foreach (vecs[k]) begin
      v0 = n_valid; e0 = n_err; o0 = n_ovf;
      applyStimulus(vecs[k].data, vecs[k].bad_par, -1);
      if (vecs[k].exp_valid != 0) exp_scan = vecs[k].data;
      checkOutput($sformatf("v%0d scan_valid", k), 32'(n_valid - v0), 32'(vecs[k].exp_valid));
      checkOutput($sformatf("v%0d frame_err", k), 32'(n_err - e0), 32'(vecs[k].exp_err));
      checkOutput($sformatf("v%0d key_ovf", k), 32'(n_ovf - o0), 32'(vecs[k].exp_ovf));
      checkOutput($sformatf("v%0d scandata", k), 32'(scandata), 32'(exp_scan));
      checkOutput($sformatf("v%0d key_on", k), 32'(key_on), 32'(vecs[k].exp_on));
      checkOutput($sformatf("v%0d key_code", k), 32'(key_code), 32'(vecs[k].exp_code));
      checkOutput($sformatf("v%0d key_count", k), 32'(key_count), 32'(vecs[k].exp_cnt));
    end

    // clear flushes the table; held across a make, it still wins over the update.
    applyStimulus(8'h1C, 0, -1);
    checkOutput("pre-clear key_on", 32'(key_on), 32'h1);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    wait_cyc(1);
    checkOutput("clear key_on", 32'(key_on), 0);
    checkOutput("clear key_code", 32'(key_code), 32'({9'h0F0, 9'h0F0}));
    checkOutput("clear key_count", 32'(key_count), 0);
    v0 = n_valid;
    clear = 1'b1;
    applyStimulus(8'h1B, 0, -1);
    clear = 1'b0;
    wait_cyc(1);
    checkOutput("clear-win scan_valid", 32'(n_valid - v0), 1);
    checkOutput("clear-win scandata", 32'(scandata), 32'h1B);
    checkOutput("clear-win key_on", 32'(key_on), 0);

    // Short glitch on ps2_clk mid-frame must not add a bit.
    v0 = n_valid; e0 = n_err;
    applyStimulus(8'h1C, 0, 4);
    checkOutput("glitch scan_valid", 32'(n_valid - v0), 1);
    checkOutput("glitch frame_err", 32'(n_err - e0), 0);
    checkOutput("glitch scandata", 32'(scandata), 32'h1C);
    checkOutput("glitch key_code", 32'(key_code), 32'({9'h0F0, 9'h01C}));

    // Stalled frame: start plus five data bits, then silence past the timeout.
    v0 = n_valid; e0 = n_err;
    send_bits(make_frame(8'h1B, 0), 6, -1);
    wait_cyc(TIMEOUT_CYC + 2);
    checkOutput("timeout frame_err", 32'(n_err - e0), 1);
    checkOutput("timeout scan_valid", 32'(n_valid - v0), 0);
    v0 = n_valid; e0 = n_err;
    applyStimulus(8'h1B, 0, -1);
    checkOutput("post-timeout scan_valid", 32'(n_valid - v0), 1);
    checkOutput("post-timeout frame_err", 32'(n_err - e0), 0);
    checkOutput("post-timeout scandata", 32'(scandata), 32'h1B);
    checkOutput("post-timeout key_code", 32'(key_code), 32'({9'h01B, 9'h01C}));
    checkOutput("post-timeout key_count", 32'(key_count), 2);

    // Reset mid-frame drops the frame silently and flushes the table.
    e0 = n_err;
    send_bits(make_frame(8'h23, 0), 4, -1);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(TIMEOUT_CYC + 20);
    checkOutput("midreset frame_err", 32'(n_err - e0), 0);
    checkOutput("midreset key_on", 32'(key_on), 0);
    checkOutput("midreset scandata", 32'(scandata), 0);
    v0 = n_valid;
    applyStimulus(8'h23, 0, -1);
    checkOutput("post-reset scan_valid", 32'(n_valid - v0), 1);
    checkOutput("post-reset key_code", 32'(key_code), 32'({9'h0F0, 9'h023}));
    checkOutput("post-reset key_count", 32'(key_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
